// File: rtl/cart_mem_arbiter_if.sv
// cart_mem_arbiter_if: requester A/B, memory channel and status bundle.
// slave = arbiter side, master = mapper/coprocessor/memory side.
interface cart_mem_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [15:0]       a_d;
  logic              a_word;
  logic              a_ack;
  logic [15:0]       a_q;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_we;
  logic [15:0]       b_d;
  logic              b_word;
  logic              b_ack;
  logic [15:0]       b_q;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_d;
  logic              mem_word;
  logic              mem_ack;
  logic [15:0]       mem_q;

  logic              owner_b;
  logic              timeout_err;

  modport slave (
    input  a_req, a_addr, a_we, a_d, a_word,
    output a_ack, a_q,
    input  b_req, b_addr, b_we, b_d, b_word,
    output b_ack, b_q,
    output mem_req, mem_addr, mem_we, mem_d, mem_word,
    input  mem_ack, mem_q,
    output owner_b, timeout_err
  );

  modport master (
    output a_req, a_addr, a_we, a_d, a_word,
    input  a_ack, a_q,
    output b_req, b_addr, b_we, b_d, b_word,
    input  b_ack, b_q,
    input  mem_req, mem_addr, mem_we, mem_d, mem_word,
    output mem_ack, mem_q,
    input  owner_b, timeout_err
  );
endinterface

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: A-priority arbiter for the cartridge memory channel.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module cart_mem_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int MAX_SKIP = 3,
  parameter int TIMEOUT  = 255
) (
  input logic               mclk,
  input logic               rst,
  cart_mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SKW =
    (MAX_SKIP < 4) ? 2 : $clog2(MAX_SKIP + 1);
  localparam logic [SKW-1:0] SKIP_TOP = SKW'(MAX_SKIP);

  logic [1:0]     state;
  logic [SKW-1:0] skip_cnt;
  logic           any_req;
  logic           pick_b;
  logic           grant;
  logic           finish;
  logic           expired;
  logic [15:0]    fin_q;

  // Winner selection and completion qualifiers
  always_comb begin
    any_req = bus.a_req | bus.b_req;
    pick_b  = bus.b_req &
              (~bus.a_req | (skip_cnt == SKIP_TOP));
    grant   = (state == IDLE) & any_req;
    finish  = (state == BUSY) & (bus.mem_ack | expired);
    fin_q   = bus.mem_ack ? bus.mem_q : 16'hFFFF;
  end

  // IDLE -> BUSY -> DONE -> IDLE; DONE is the dead cycle
  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (any_req) state <= BUSY;
        BUSY:    if (finish) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count A grants that jumped a waiting B
  always_ff @(posedge mclk) begin
    if (rst) begin
      skip_cnt <= '0;
    end else if (grant) begin
      if (pick_b) begin
        skip_cnt <= '0;
      end else if (bus.b_req &&
                   skip_cnt != SKIP_TOP) begin
        skip_cnt <= skip_cnt + 1'b1;
      end
    end
  end

  // Latch the winner's command and pulse mem_req
  always_ff @(posedge mclk) begin
    if (rst) begin
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= {ADDR_W{1'b0}};
      bus.mem_we   <= 1'b0;
      bus.mem_d    <= 16'h0000;
      bus.mem_word <= 1'b0;
      bus.owner_b  <= 1'b0;
    end else begin
      bus.mem_req <= grant;
      if (grant) begin
        bus.owner_b <= pick_b;
        if (pick_b) begin
          bus.mem_addr <= bus.b_addr;
          bus.mem_we   <= bus.b_we;
          bus.mem_d    <= bus.b_d;
          bus.mem_word <= bus.b_word;
        end else begin
          bus.mem_addr <= bus.a_addr;
          bus.mem_we   <= bus.a_we;
          bus.mem_d    <= bus.a_d;
          bus.mem_word <= bus.a_word;
        end
      end
    end
  end

  // Completion: ack pulse and q load for the owner only
  always_ff @(posedge mclk) begin
    if (rst) begin
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.a_q   <= 16'h0000;
      bus.b_q   <= 16'h0000;
    end else begin
      bus.a_ack <= finish & ~bus.owner_b;
      bus.b_ack <= finish & bus.owner_b;
      if (finish && !bus.owner_b) bus.a_q <= fin_q;
      if (finish && bus.owner_b)  bus.b_q <= fin_q;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] busy_cnt;

  // Last BUSY cycle before a forced completion
  assign expired = (busy_cnt == TW'(TIMEOUT - 1));

  // Cycles spent in BUSY since the grant
  always_ff @(posedge mclk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (grant) begin
      busy_cnt <= '0;
    end else if (state == BUSY && !expired) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  // Sticky flag: set on a forced completion
  always_ff @(posedge mclk) begin
    if (rst) begin
      bus.timeout_err <= 1'b0;
    end else if (finish && !bus.mem_ack) begin
      bus.timeout_err <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  // TIMEOUT is a non-negative count, so this ties the flag low
  assign bus.timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: directed bench with a transaction-level model.
// Timeout scenario only runs when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cart_mem_arbiter;
  localparam int AW = 24;
  localparam int MS = 3;
  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  cart_mem_arbiter_if #(.ADDR_W(AW)) bus();

  cart_mem_arbiter #(
    .ADDR_W(AW), .MAX_SKIP(MS), .TIMEOUT(TO)
  ) dut (
    .mclk(mclk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          mem_on = 1'b1;
  int          mem_lat = 3;
  logic [15:0] mem_data = 16'h0000;
  int          stray_req = 0;
  int          stray_seen = 0;
  bit          pend = 1'b0;
  int          pcnt = 0;
  bit          fire;

  always @(negedge mclk) begin
    fire = 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        fire = 1'b1;
        pend = 1'b0;
      end else begin
        pcnt--;
      end
    end
    if (bus.mem_req === 1'b1 && mem_on) begin
      if (mem_lat == 0) fire = 1'b1;
      else begin
        pend = 1'b1;
        pcnt = mem_lat - 1;
      end
    end
    if (stray_seen != stray_req) begin
      fire = 1'b1;
      stray_seen = stray_req;
    end
    bus.mem_ack = fire;
    bus.mem_q   = mem_data;
  end

  // ---------------- behavioural model ----------------
  // One operation at a time; a new grant is allowed two
  // edges after the completing edge.
  logic          e_a_ack, e_b_ack, e_mem_req;
  logic [15:0]   e_a_q, e_b_q, e_mem_d;
  logic [AW-1:0] e_mem_addr;
  logic          e_mem_we, e_mem_word, e_owner_b, e_terr;
  int  m_cyc = 0, m_gcyc = 0, m_ready = 0, m_skips = 0;
  bit  m_busy = 1'b0, started = 1'b0, take_b;

  task automatic m_finish(input logic [15:0] q);
    if (e_owner_b) begin
      e_b_ack = 1'b1;
      e_b_q   = q;
    end else begin
      e_a_ack = 1'b1;
      e_a_q   = q;
    end
    m_busy  = 1'b0;
    m_ready = m_cyc + 2;
  endtask

  always @(posedge mclk) begin
    m_cyc++;
    e_a_ack = 1'b0;
    e_b_ack = 1'b0;
    e_mem_req = 1'b0;
    if (rst) begin
      started = 1'b1;
      m_busy = 1'b0;
      m_ready = 0;
      m_skips = 0;
      e_a_q = '0; e_b_q = '0; e_mem_d = '0;
      e_mem_addr = '0; e_mem_we = 1'b0;
      e_mem_word = 1'b0; e_owner_b = 1'b0;
      e_terr = 1'b0;
    end else if (m_busy) begin
      if (bus.mem_ack) begin
        m_finish(bus.mem_q);
      end else if (TO_EN && m_cyc - m_gcyc == TO) begin
        m_finish(16'hFFFF);
        e_terr = 1'b1;
      end
    end else if (m_cyc >= m_ready &&
                 (bus.a_req || bus.b_req)) begin
      take_b = bus.b_req &&
               (!bus.a_req || m_skips >= MS);
      if (take_b) m_skips = 0;
      else if (bus.b_req && m_skips < MS) m_skips++;
      e_owner_b  = take_b;
      e_mem_addr = take_b ? bus.b_addr : bus.a_addr;
      e_mem_we   = take_b ? bus.b_we : bus.a_we;
      e_mem_d    = take_b ? bus.b_d : bus.a_d;
      e_mem_word = take_b ? bus.b_word : bus.a_word;
      e_mem_req  = 1'b1;
      m_busy = 1'b1;
      m_gcyc = m_cyc;
    end
  end

  // ---------------- monitor state ----------------
  bit log_q[$];
  int n_req = 0, n_a = 0, n_b = 0;
  int mon_cyc = 0, g_cyc = 0, b_cyc = 0;

  task automatic compare_loop();
    forever begin
      @(negedge mclk);
      if (started) begin
        chk("a_ack", 32'(bus.a_ack), 32'(e_a_ack));
        chk("b_ack", 32'(bus.b_ack), 32'(e_b_ack));
        chk("a_q", 32'(bus.a_q), 32'(e_a_q));
        chk("b_q", 32'(bus.b_q), 32'(e_b_q));
        chk("mem_req", 32'(bus.mem_req), 32'(e_mem_req));
        chk("mem_addr", 32'(bus.mem_addr),
            32'(e_mem_addr));
        chk("mem_we", 32'(bus.mem_we), 32'(e_mem_we));
        chk("mem_d", 32'(bus.mem_d), 32'(e_mem_d));
        chk("mem_word", 32'(bus.mem_word),
            32'(e_mem_word));
        chk("owner_b", 32'(bus.owner_b), 32'(e_owner_b));
        chk("timeout_err", 32'(bus.timeout_err),
            32'(e_terr));
      end
      mon_cyc++;
      if (bus.mem_req === 1'b1) begin
        log_q.push_back(bus.owner_b);
        n_req++;
        g_cyc = mon_cyc;
      end
      if (bus.a_ack === 1'b1) n_a++;
      if (bus.b_ack === 1'b1) begin
        n_b++;
        b_cyc = mon_cyc;
      end
    end
  endtask

  // ---------------- requester ----------------
  task automatic op(input bit pb,
                    input logic [AW-1:0] addr,
                    input logic we,
                    input logic [15:0] d,
                    input logic word,
                    input int late);
    bit got;
    if (pb) begin
      bus.b_addr = addr; bus.b_we = we;
      bus.b_d = d; bus.b_word = word;
      bus.b_req = 1'b1;
    end else begin
      bus.a_addr = addr; bus.a_we = we;
      bus.a_d = d; bus.a_word = word;
      bus.a_req = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge mclk);
      got = pb ? bus.b_ack : bus.a_ack;
    end
    if (pb) chk("b_ack_wait", 32'(got), 32'd1);
    else    chk("a_ack_wait", 32'(got), 32'd1);
    repeat (late) @(negedge mclk);
    if (pb) bus.b_req = 1'b0;
    else    bus.a_req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge mclk);
    #1;
  endtask

  int  base_log, base_req, base_a;
  bit  b_done;

  initial begin
    bus.a_req = 0; bus.a_addr = '0; bus.a_we = 0;
    bus.a_d = '0; bus.a_word = 0;
    bus.b_req = 0; bus.b_addr = '0; bus.b_we = 0;
    bus.b_d = '0; bus.b_word = 0;
    fork
      compare_loop();
    join_none

    // reset state
    settle(3);
    rst = 1'b0;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_a_q", 32'(bus.a_q), 32'd0);

    // B write to give b_q a known value
    mem_lat = 2; mem_data = 16'h1111;
    op(1, 24'h00BEAD, 1, 16'hC0DE, 1, 0);
    settle(2);
    chk("b_q_load", 32'(bus.b_q), 32'h1111);

    // A read at 0x123456, data BEEF after 3 cycles
    mem_lat = 3; mem_data = 16'hBEEF;
    base_a = n_a;
    op(0, 24'h123456, 0, 16'h0000, 1, 0);
    settle(2);
    chk("a_read_q", 32'(bus.a_q), 32'hBEEF);
    chk("model_a_q", 32'(e_a_q), 32'hBEEF);
    chk("a_read_addr", 32'(bus.mem_addr), 32'h123456);
    chk("a_read_owner", 32'(bus.owner_b), 32'd0);
    chk("b_q_kept", 32'(bus.b_q), 32'h1111);
    chk("a_ack_pulses", 32'(n_a - base_a), 32'd1);

    // simultaneous single requests, earliest ack
    mem_lat = 0; mem_data = 16'h2222;
    base_log = log_q.size();
    fork
      op(0, 24'h000010, 0, 16'h0, 0, 0);
      op(1, 24'h000020, 0, 16'h0, 0, 0);
    join
    settle(2);
    chk("sim_count", 32'(log_q.size() - base_log), 32'd2);
    if (log_q.size() >= base_log + 2) begin
      chk("sim_first", 32'(log_q[base_log]), 32'd0);
      chk("sim_second", 32'(log_q[base_log + 1]), 32'd1);
    end

    // starvation: A keeps coming back while B waits
    mem_lat = 1; mem_data = 16'h3333;
    base_log = log_q.size();
    b_done = 1'b0;
    fork
      begin
        while (!b_done) begin
          op(0, 24'h000100, 0, 16'h0, 1, 0);
          @(negedge mclk);
        end
      end
      begin
        op(1, 24'h000200, 0, 16'h0, 1, 0);
        b_done = 1'b1;
      end
    join
    settle(3);
    chk("starv_count_ge4",
        32'(log_q.size() - base_log >= 4), 32'd1);
    if (log_q.size() >= base_log + 4) begin
      for (int i = 0; i < 4; i++)
        chk("starv_order", 32'(log_q[base_log + i]),
            (i == 3) ? 32'd1 : 32'd0);
    end

    // skip count cleared by the B grant: A wins again
    base_log = log_q.size();
    fork
      op(0, 24'h000300, 0, 16'h0, 0, 0);
      op(1, 24'h000400, 0, 16'h0, 0, 0);
    join
    settle(2);
    if (log_q.size() >= base_log + 1)
      chk("skip_cleared", 32'(log_q[base_log]), 32'd0);

    // dead cycle: a_req held one cycle past a_ack
    base_req = n_req; base_a = n_a;
    op(0, 24'h000500, 1, 16'hA5A5, 1, 1);
    settle(5);
    chk("dead_req_pulses", 32'(n_req - base_req), 32'd1);
    chk("dead_ack_pulses", 32'(n_a - base_a), 32'd1);

    // reset in the middle of BUSY
    mem_on = 1'b0;
    bus.a_addr = 24'h00CAFE; bus.a_req = 1'b1;
    settle(3);
    rst = 1'b1;
    bus.a_req = 1'b0;
    settle(2);
    chk("rst_busy_a_q", 32'(bus.a_q), 32'd0);
    chk("rst_busy_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy_owner", 32'(bus.owner_b), 32'd0);
    rst = 1'b0;
    base_req = n_req; base_a = n_a;
    stray_req++;
    settle(4);
    chk("stray_no_ack", 32'(n_a - base_a), 32'd0);
    chk("stray_no_req", 32'(n_req - base_req), 32'd0);
    mem_on = 1'b1; mem_lat = 2; mem_data = 16'h5AA5;
    op(0, 24'h000777, 0, 16'h0, 1, 0);
    settle(2);
    chk("post_rst_a_q", 32'(bus.a_q), 32'h5AA5);

`ifdef ARB_TIMEOUT_EN
    // watchdog: no mem_ack at all
    mem_on = 1'b0;
    op(1, 24'h00ABCD, 0, 16'h0, 1, 0);
    settle(1);
    chk("to_latency", 32'(b_cyc - g_cyc), 32'(TO));
    chk("to_b_q", 32'(bus.b_q), 32'hFFFF);
    chk("to_err_set", 32'(bus.timeout_err), 32'd1);
    mem_on = 1'b1; mem_data = 16'h7777;
    op(0, 24'h000888, 0, 16'h0, 1, 0);
    settle(2);
    chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    chk("to_err_clear", 32'(bus.timeout_err), 32'd0);
`endif

    settle(2);
    chk("final_terr", 32'(bus.timeout_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_mem_arbiter.md
# cart_mem_arbiter

Shares the single cartridge memory port (ROM/BSRAM SDRAM channel) between two requesters: port A, the CPU-side mapper path, and port B, a coprocessor or background loader. Both use a level-request/pulse-acknowledge handshake. Port A has priority; bounded starvation protection guarantees port B progress. It sits between the mapper/coprocessor outputs and the external memory controller.

## Interface
Parameters:
- ADDR_W, 24, address width of all ports
- MAX_SKIP, 3, consecutive A grants allowed while B waits before B is forced
- TIMEOUT, 255, BUSY cycles before forced completion (only with ARB_TIMEOUT_EN)

Ports:
- mclk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  port A request, level, held until a_ack
- a_addr  in  ADDR_W  port A address
- a_we  in  1  port A write (1) / read (0)
- a_d  in  16  port A write data
- a_word  in  1  port A 16-bit access (0 = byte)
- a_ack  out  1  port A completion pulse, 1 cycle
- a_q  out  16  port A read data, valid with a_ack, held until next A completion
- b_req, b_addr, b_we, b_d, b_word, b_ack, b_q: same as port A, for port B
- mem_req  out  1  memory request pulse, 1 cycle
- mem_addr  out  ADDR_W  latched address
- mem_we, mem_d, mem_word  out  1/16/1  latched command fields
- mem_ack  in  1  memory completion pulse; mem_q valid same cycle
- mem_q  in  16  memory read data
- owner_b  out  1  current/last operation belongs to B
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if a_req or b_req, grant and go BUSY. Selection: B if b_req and (!a_req or skip_cnt == MAX_SKIP); else A. Latch addr/we/d/word of winner into mem_*, set owner_b, pulse mem_req.
- skip_cnt (2+ bits, saturating at MAX_SKIP): increments on an A grant while b_req high; clears on any B grant.
- BUSY: wait for mem_ack. mem_ack ignored in IDLE and DONE (stale acks after reset are dropped).
- On mem_ack in BUSY: pulse winner's ack, load winner's q from mem_q (reads and writes both load it), go DONE. Other port's q is unchanged.
- DONE: one dead cycle, no grant; go IDLE. Requesters must drop req in the cycle they see ack; the dead cycle ensures a stale req is never re-granted.
- Command fields latched at grant; requester changes or drops req after grant do not abort the operation, and ack still pulses.
- Reset: state IDLE, skip_cnt 0, all outputs 0 (a_ack, b_ack, a_q, b_q, mem_req, mem_addr, mem_we, mem_d, mem_word, owner_b, timeout_err). Reset mid-BUSY abandons the operation without an ack.

## Timing
- Request sampled high before edge k in IDLE: mem_req high and mem_* valid after edge k; mem_req low after edge k+1.
- mem_ack may arrive as early as the cycle mem_req is high.
- mem_ack high before edge m: x_ack and x_q valid after edge m for one cycle; state IDLE after edge m+1; next grant earliest at edge m+2.
- Minimum A-to-ack latency: 2 cycles. Back-to-back throughput: one operation per (memory latency + 3) cycles.
- Simultaneous a_req and b_req: resolved by the skip rule; at most MAX_SKIP+1 operations between B's request and B's grant when A saturates.

## Configuration
- ARB_TIMEOUT_EN defined: a cycle counter runs in BUSY, cleared on grant. When it reaches TIMEOUT without mem_ack, the arbiter completes as if mem_ack arrived, with q = 16'hFFFF, and sets timeout_err (cleared only by rst).
- ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err tied 0.

## Test plan
- Reset: assert rst 2 cycles mid-BUSY -> all outputs 0, no ack; a later mem_ack is ignored; next a_req served normally.
- A read: a_req, a_addr=0x123456, mem_ack 3 cycles after mem_req with mem_q=0xBEEF -> mem_addr=0x123456, one a_ack pulse with a_q=0xBEEF, owner_b=0, b_q unchanged.
- Simultaneous single requests: a_req and b_req same cycle, skip_cnt=0 -> A served first, then B granted after the DONE cycle with owner_b=1.
- Starvation: b_req held, A re-requests continuously, MAX_SKIP=3 -> exactly 3 A operations, then B; skip_cnt back to 0.
- Dead cycle: requester holds a_req one cycle past a_ack -> no second grant; mem_req pulses exactly once.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): no mem_ack -> b_ack at BUSY cycle 8 with b_q=0xFFFF, timeout_err=1 until rst.
